// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Hands ownership of the shared 16-bit BUS to one register block at a time
// (IR, PC, AC, ...) by driving their LDBUS enables. Requesters are served
// round-robin. Between two owners the bus is held idle for one dead cycle
// (TURN) so that two tri-state drivers never overlap.
//
// Optional feature (compile-time macro BUS_ARB_PRIO_EN):
//   defined   - requester 0 (instruction-fetch path) wins every arbitration
//               it takes part in. A grant to requester 0 leaves rr_ptr alone,
//               so the other requesters keep their round-robin order.
//   undefined - pure round-robin over all requesters.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   req      in   [N_REQ] per-requester bus request (level)
//   lock     in   [N_REQ] per-requester hold request (only meaningful with req)
//   ldbus    out  [N_REQ] registered one-hot LDBUS enables
//   grant_id out  [ID_W]  index of the current owner (valid when bus_busy=1)
//   bus_busy out  registered OR of ldbus
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] lock,
    output logic [N_REQ-1:0] ldbus,
    output logic [ID_W-1:0]  grant_id,
    output logic             bus_busy
);

    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;

    logic [1:0]        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic [1:0]        state_nxt;
    logic [ID_W-1:0]   rr_ptr_nxt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic [N_REQ-1:0]  ldbus_nxt;
    logic [ID_W-1:0]   grant_id_nxt;

    logic [N_REQ-1:0]  owner_oh;
    logic [N_REQ-1:0]  others;
    logic [N_REQ-1:0]  arb_req;
    logic [ID_W:0]     pick_res;
    logic              win_found;
    logic [ID_W-1:0]   win_idx;

    // Returns {found, index} of the first set bit of r, scanning upward from
    // ptr+1 with wrap-around.
    function automatic logic [ID_W:0] pick(input logic [N_REQ-1:0] r,
                                           input logic [ID_W-1:0]  ptr);
        logic            found;
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
`ifdef BUS_ARB_PRIO_EN
        if (r[0]) begin
            found = 1'b1;
            idx   = '0;
        end
`endif
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ID_W'((int'(ptr) + i) % N_REQ);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // In TURN the previous owner is masked out whenever anyone else is
    // waiting. Plain round-robin already ranks it last, but with the priority
    // option requester 0 would otherwise win back-to-back forever.
    always_comb begin
        owner_oh = N_REQ'(1) << grant_id;
        others   = req & ~owner_oh;
        arb_req  = req;
        if (state == S_TURN && others != '0) begin
            arb_req = others;
        end
        pick_res  = pick(arb_req, rr_ptr);
        win_found = pick_res[ID_W];
        win_idx   = pick_res[ID_W-1:0];
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        hold_cnt_nxt = hold_cnt;
        ldbus_nxt    = ldbus;
        grant_id_nxt = grant_id;
        case (state)
            S_IDLE, S_TURN: begin
                if (win_found) begin
                    state_nxt    = S_GRANT;
                    ldbus_nxt    = N_REQ'(1) << win_idx;
                    grant_id_nxt = win_idx;
                    hold_cnt_nxt = '0;
                end else begin
                    state_nxt = S_IDLE;
                    ldbus_nxt = '0;
                end
            end
            S_GRANT: begin
                // Dropping req is treated exactly like dropping lock.
                if (req[grant_id] && lock[grant_id] &&
                    hold_cnt < HOLD_W'(MAX_HOLD - 1)) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end else begin
                    state_nxt    = S_TURN;
                    ldbus_nxt    = '0;
                    hold_cnt_nxt = '0;
`ifdef BUS_ARB_PRIO_EN
                    if (grant_id != '0) begin
                        rr_ptr_nxt = grant_id;
                    end
`else
                    rr_ptr_nxt = grant_id;
`endif
                end
            end
            default: begin
                state_nxt    = S_IDLE;
                ldbus_nxt    = '0;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ldbus    <= '0;
            grant_id <= '0;
            bus_busy <= 1'b0;
            rr_ptr   <= ID_W'(N_REQ - 1);
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ldbus    <= ldbus_nxt;
            grant_id <= grant_id_nxt;
            bus_busy <= |ldbus_nxt;
            rr_ptr   <= rr_ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter (N_REQ=4, MAX_HOLD=8). Each stimulus row is
// applied on the falling edge together with the hand-computed ldbus value
// expected after the following rising edge; that value is queued and a
// separate monitor pops it shortly after the rising edge and checks ldbus,
// bus_busy and (when the bus is owned) grant_id.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] ldbus;
    logic [1:0] grant_id;
    logic       bus_busy;

    int n_cmp;
    int n_bad;

    logic [3:0] exp_q[$];

    bus_arbiter #(
        .N_REQ    (4),
        .MAX_HOLD (8),
        .ID_W     (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .ldbus    (ldbus),
        .grant_id (grant_id),
        .bus_busy (bus_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one row of stimulus and queue the ldbus expected after the edge.
    task automatic row(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic [3:0] ex);
        @(negedge clk);
        rst  = r;
        req  = rq;
        lock = lk;
        exp_q.push_back(ex);
    endtask

    // Monitor / scoreboard.
    initial begin
        logic [3:0] e;
        logic [1:0] eid;
        int         step;
        step = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                step++;
                n_cmp++;
                if (ldbus !== e) begin
                    n_bad++;
                    $display("FAIL ldbus step %0d: got %b want %b", step, ldbus, e);
                end
                n_cmp++;
                if (bus_busy !== (|e)) begin
                    n_bad++;
                    $display("FAIL bus_busy step %0d: got %b want %b", step, bus_busy, |e);
                end
                if (e != 4'b0000) begin
                    eid = 2'd0;
                    for (int i = 0; i < 4; i++) begin
                        if (e[i]) eid = 2'(i);
                    end
                    n_cmp++;
                    if (grant_id !== eid) begin
                        n_bad++;
                        $display("FAIL grant_id step %0d: got %0d want %0d", step, grant_id, eid);
                    end
                end
            end
        end
    end

    initial begin
        int waited;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        req   = 4'b1111;
        lock  = 4'b0000;

        // Reset held with all requests pending: bus must stay idle.
        row(1'b1, 4'b1111, 4'b0000, 4'b0000);
        row(1'b1, 4'b1111, 4'b0000, 4'b0000);

        // Round-robin with everyone requesting, one dead cycle between owners.
`ifdef BUS_ARB_PRIO_EN
        row(1'b0, 4'b1111, 4'b0000, 4'b0001);
        row(1'b0, 4'b1111, 4'b0000, 4'b0000);
        row(1'b0, 4'b1111, 4'b0000, 4'b0010);
        row(1'b0, 4'b1111, 4'b0000, 4'b0000);
        row(1'b0, 4'b1111, 4'b0000, 4'b0001);
        row(1'b0, 4'b1111, 4'b0000, 4'b0000);
        row(1'b0, 4'b1111, 4'b0000, 4'b0100);
        row(1'b0, 4'b1111, 4'b0000, 4'b0000);
        row(1'b0, 4'b1111, 4'b0000, 4'b0001);
        row(1'b0, 4'b1111, 4'b0000, 4'b0000);
`else
        row(1'b0, 4'b1111, 4'b0000, 4'b0001);
        row(1'b0, 4'b1111, 4'b0000, 4'b0000);
        row(1'b0, 4'b1111, 4'b0000, 4'b0010);
        row(1'b0, 4'b1111, 4'b0000, 4'b0000);
        row(1'b0, 4'b1111, 4'b0000, 4'b0100);
        row(1'b0, 4'b1111, 4'b0000, 4'b0000);
        row(1'b0, 4'b1111, 4'b0000, 4'b1000);
        row(1'b0, 4'b1111, 4'b0000, 4'b0000);
        row(1'b0, 4'b1111, 4'b0000, 4'b0001);
        row(1'b0, 4'b1111, 4'b0000, 4'b0000);
`endif
        // Requests gone: back to idle; lock without req does nothing.
        row(1'b0, 4'b0000, 4'b0000, 4'b0000);
        row(1'b0, 4'b0000, 4'b1111, 4'b0000);

        // Hold limit: owner 1 locked keeps the bus for exactly 8 cycles.
        for (int i = 0; i < 8; i++) begin
            row(1'b0, 4'b0110, 4'b0010, 4'b0010);
        end
        row(1'b0, 4'b0110, 4'b0010, 4'b0000);
        row(1'b0, 4'b0110, 4'b0010, 4'b0100);
        row(1'b0, 4'b0000, 4'b0000, 4'b0000);
        row(1'b0, 4'b0000, 4'b0000, 4'b0000);

        // Early release: owner 2 locked, req[2] dropped during 3rd grant cycle.
        row(1'b0, 4'b0100, 4'b0100, 4'b0100);
        row(1'b0, 4'b1100, 4'b0100, 4'b0100);
        row(1'b0, 4'b1100, 4'b0100, 4'b0100);
        row(1'b0, 4'b1000, 4'b0100, 4'b0000);
        row(1'b0, 4'b1000, 4'b0000, 4'b1000);
        row(1'b0, 4'b0000, 4'b0000, 4'b0000);
        row(1'b0, 4'b0000, 4'b0000, 4'b0000);

        // Reset mid-grant drops ldbus at that very edge; grant resumes after.
        row(1'b0, 4'b0010, 4'b0010, 4'b0010);
        row(1'b0, 4'b0010, 4'b0010, 4'b0010);
        row(1'b1, 4'b0010, 4'b0010, 4'b0000);
        row(1'b0, 4'b0010, 4'b0000, 4'b0010);
        row(1'b0, 4'b0000, 4'b0000, 4'b0000);
        row(1'b0, 4'b0000, 4'b0000, 4'b0000);

        // Wait, bounded, for the monitor to drain the queue.
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #5;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d entries left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Sequences ownership of the shared 16-bit BUS between register blocks (IR, PC, AC, etc.) that place data on it through their LDBUS enables. Round-robin arbitration over N_REQ requesters. Produces one-hot LDBUS enables, so at most one register drives the bus in any cycle. A forced dead cycle separates owners to prevent tri-state overlap.

Parameters:
N_REQ, 4, number of bus requesters (2..8)
MAX_HOLD, 8, max consecutive grant cycles for one owner (1..16)
ID_W, 2, width of grant_id; must equal clog2(N_REQ)

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
req  input  N_REQ  per-requester bus request, level-sensitive
lock  input  N_REQ  per-requester hold request; owner keeps bus while req&lock
ldbus  output  N_REQ  one-hot LDBUS enables to register blocks (registered)
grant_id  output  ID_W  index of current owner; valid only when bus_busy=1
bus_busy  output  1  high when any ldbus bit is high

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, ldbus=0, grant_id=0, bus_busy=0, rr_ptr=N_REQ-1, hold_cnt=0. rst dominates all other inputs. Reset during GRANT drops ldbus to 0 at that same edge.
- States: IDLE, GRANT, TURN. All outputs are registered.
- Winner selection: first requester with req high, searching upward from (rr_ptr+1) mod N_REQ with wrap-around.
- IDLE: if any req bit is high, latch the winner, set ldbus[winner]=1, grant_id=winner, hold_cnt=0, go to GRANT. Latency is 1 cycle from req to ldbus. Otherwise stay in IDLE.
- GRANT: ldbus stays on the owner.
  - Stay in GRANT, with hold_cnt+1, only if req[owner]=1, lock[owner]=1 and hold_cnt < MAX_HOLD-1.
  - Otherwise go to TURN, clear ldbus, set rr_ptr=owner.
  - Minimum grant is 1 cycle. Maximum grant is MAX_HOLD cycles.
- TURN: exactly 1 cycle with ldbus=0.
  - If any req bit is high, select the winner against the updated rr_ptr, go to GRANT, and assert that grant at this edge.
  - Otherwise go to IDLE.
- Fairness: the previous owner cannot win the arbitration immediately after its own grant while any other requester is high.
- Owner drops req mid-grant: treated as release. Same handling as lock low.
- req/lock bits of non-owners during GRANT are ignored until TURN.
- lock without req has no effect.
- Invariant: ldbus is zero or one-hot in every cycle. bus_busy equals OR of ldbus.
- hold_cnt width is clog2(MAX_HOLD)+1 and never exceeds MAX_HOLD-1.

Optional Feature:
BUS_ARB_PRIO_EN
- Defined:
  - Requester 0 (IR/instruction-fetch path) has fixed priority. If req[0]=1 at any arbitration point (IDLE or TURN), requester 0 wins regardless of rr_ptr.
  - A grant to requester 0 does not update rr_ptr.
  - The other requesters keep round-robin order among themselves.
- Undefined: pure round-robin for all requesters, as described in Behaviour.

Test Plan:
1. Reset/idle: hold rst=1 for 2 cycles with req=4'b1111 → ldbus=0, bus_busy=0. First edge after rst=0 → ldbus=4'b0001, grant_id=0.
2. Round-robin: req=4'b1111, lock=0, held constant from IDLE → ldbus sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001 (dead cycle between each grant).
3. Hold limit: req=4'b0110, lock=4'b0010, MAX_HOLD=8 → ldbus=0010 for exactly 8 cycles, then 0000 for 1 cycle, then 0100.
4. Early release: owner 2 locked. Drop req[2] in its 3rd grant cycle → ldbus=0 at the next edge. With req[3]=1, ldbus=1000 one cycle later.
5. Reset mid-grant: rst=1 during the 2nd cycle of grant to requester 1 → ldbus=0 at that edge. After release with req=4'b0010 → ldbus=0010 again (rr_ptr reset to 3).
6. With BUS_ARB_PRIO_EN: req=4'b1111, lock=0 → grants 0,1,0,2,0,3 (TURN between each). Without the macro, the same stimulus gives 0,1,2,3.
